// File: rtl/bit_serializer_if.sv
// bit_serializer_if: word handshake in, serial bit stream out.
interface bit_serializer_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             x;
    logic             x_valid;
    logic             last;
    modport master (output in_data, in_valid, input in_ready, x, x_valid, last);
    modport slave  (input in_data, in_valid, output in_ready, x, x_valid, last);
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the sequence detector, one bit per clock on x.
// Define SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  logic                clk,
    input  logic                reset,
    bit_serializer_if.slave     bus,
    output logic                busy,
    output logic [15:0]         word_count
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, PAR, GAPS} state_t;
    state_t           state, nxt, after;
    logic [WIDTH-1:0] sr, sr_n, src;
    logic [CW-1:0]    cnt, cnt_n;
    logic [7:0]       gcnt, gcnt_n;
    logic             accept, fin, x_n, xv_n, last_n;
`ifdef SERIALIZER_PARITY_EN
    localparam bit PEN = 1'b1;
    logic par;
    always_ff @(posedge clk or posedge reset)
        if (reset) par <= 1'b0;
        else par <= accept ? ^bus.in_data : par;
`else
    localparam bit PEN = 1'b0;
`endif
    // With no gap, the final frame bit doubles as an accept slot so frames run back-to-back.
    assign bus.in_ready = !reset && (state == IDLE || (GAP == 0 && bus.last));
    assign busy = state != IDLE;
    always_comb begin
        accept = bus.in_valid && bus.in_ready;
        fin    = cnt == CW'(WIDTH - 1);
        src    = accept ? bus.in_data : sr;
        after  = (GAP > 0) ? GAPS : (accept ? SHIFT : IDLE);
        nxt    = IDLE;
        case (state)
            IDLE:  nxt = accept ? SHIFT : IDLE;
            SHIFT: nxt = !fin ? SHIFT : (PEN ? PAR : after);
`ifdef SERIALIZER_PARITY_EN
            PAR:   nxt = after;
`endif
            GAPS:  nxt = (gcnt == 8'(GAP - 1)) ? IDLE : GAPS;
            default: nxt = IDLE;
        endcase
        gcnt_n = (state == GAPS) ? gcnt + 8'd1 : 8'd0;
        cnt_n  = accept ? '0 : (state == SHIFT ? cnt + 1'b1 : cnt);
        sr_n   = sr;
        x_n    = 1'b0;
        xv_n   = 1'b0;
        last_n = 1'b0;
        if (nxt == SHIFT) begin
            x_n    = MSB_FIRST ? src[WIDTH-1] : src[0];
            sr_n   = MSB_FIRST ? src << 1 : src >> 1;
            xv_n   = 1'b1;
            last_n = !PEN && cnt_n == CW'(WIDTH - 1);
        end
`ifdef SERIALIZER_PARITY_EN
        if (nxt == PAR) {x_n, xv_n, last_n} = {par, 2'b11};
`endif
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sr          <= '0;
            cnt         <= '0;
            gcnt        <= '0;
            bus.x       <= 1'b0;
            bus.x_valid <= 1'b0;
            bus.last    <= 1'b0;
            word_count  <= '0;
        end else begin
            state       <= nxt;
            sr          <= sr_n;
            cnt         <= cnt_n;
            gcnt        <= gcnt_n;
            bus.x       <= x_n;
            bus.x_valid <= xv_n;
            bus.last    <= last_n;
            word_count  <= bus.last ? word_count + 16'd1 : word_count;
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed vectors on three serializer configurations (MSB/GAP0, LSB/GAP0, MSB/GAP2).
module tb_bit_serializer;
`ifdef SERIALIZER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FL = 8 + P;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;
    logic       vld [3];
    logic [7:0] dat [3];
    logic       rdy [3], xs [3], xv [3], ls [3], bsy [3];
    logic [15:0] wc [3];
    logic [15:0] exp_wc [3];
    int n_chk = 0, n_fail = 0;
    bit_serializer_if #(.WIDTH(8)) b0 (), b1 (), b2 ();
    assign b0.in_valid = vld[0]; assign b0.in_data = dat[0];
    assign b1.in_valid = vld[1]; assign b1.in_data = dat[1];
    assign b2.in_valid = vld[2]; assign b2.in_data = dat[2];
    assign rdy[0] = b0.in_ready; assign xs[0] = b0.x; assign xv[0] = b0.x_valid; assign ls[0] = b0.last;
    assign rdy[1] = b1.in_ready; assign xs[1] = b1.x; assign xv[1] = b1.x_valid; assign ls[1] = b1.last;
    assign rdy[2] = b2.in_ready; assign xs[2] = b2.x; assign xv[2] = b2.x_valid; assign ls[2] = b2.last;
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) u0 (.clk(clk), .reset(reset), .bus(b0), .busy(bsy[0]), .word_count(wc[0]));
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(0)) u1 (.clk(clk), .reset(reset), .bus(b1), .busy(bsy[1]), .word_count(wc[1]));
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(2)) u2 (.clk(clk), .reset(reset), .bus(b2), .busy(bsy[2]), .word_count(wc[2]));
    typedef struct {
        int         sel;
        logic [7:0] data;
        logic [7:0] bits;
        logic       par;
    } vec_t;
    vec_t vt [8];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic wait_ready(input int s);
        for (int k = 0; k < 10 && !rdy[s]; k++) @(negedge clk);
        check("ready", 32'(rdy[s]), 1);
    endtask
    task automatic run_frame(input vec_t v);
        int s;
        s = v.sel;
        wait_ready(s);
        dat[s] = v.data;
        vld[s] = 1'b1;
        @(posedge clk);
        #1 vld[s] = 1'b0;
        dat[s] = ~v.data;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            check("x_valid", 32'(xv[s]), 1);
            check("x", 32'(xs[s]), (i < 8) ? 32'(v.bits[7-i]) : 32'(v.par));
            check("last", 32'(ls[s]), 32'(i == FL - 1));
            check("busy", 32'(bsy[s]), 1);
        end
        @(negedge clk);
        check("x_idle", 32'(xs[s]), 0);
        check("x_valid_idle", 32'(xv[s]), 0);
        check("last_idle", 32'(ls[s]), 0);
        exp_wc[s] = exp_wc[s] + 16'd1;
        check("word_count", 32'(wc[s]), 32'(exp_wc[s]));
    endtask
    initial begin
        int z, nr;
        vt[0] = '{0, 8'hB4, 8'hB4, 1'b0};
        vt[1] = '{1, 8'hB4, 8'h2D, 1'b0};
        vt[2] = '{0, 8'h07, 8'h07, 1'b1};
        vt[3] = '{1, 8'h07, 8'hE0, 1'b1};
        vt[4] = '{0, 8'h81, 8'h81, 1'b0};
        vt[5] = '{1, 8'h1E, 8'h78, 1'b0};
        vt[6] = '{2, 8'hB4, 8'hB4, 1'b0};
        vt[7] = '{1, 8'h01, 8'h80, 1'b1};
        for (int s = 0; s < 3; s++) begin
            vld[s] = 1'b0;
            dat[s] = 8'h00;
            exp_wc[s] = 16'd0;
        end
        #12;
        for (int s = 0; s < 3; s++) begin
            check("rst_ready", 32'(rdy[s]), 0);
            check("rst_x", 32'(xs[s]), 0);
            check("rst_x_valid", 32'(xv[s]), 0);
            check("rst_last", 32'(ls[s]), 0);
            check("rst_busy", 32'(bsy[s]), 0);
            check("rst_word_count", 32'(wc[s]), 0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) check("ready_after_rst", 32'(rdy[s]), 1);
        for (int t = 0; t < 8; t++) run_frame(vt[t]);
        // Back-to-back: FF then 00 with in_valid held high.
        wait_ready(0);
        dat[0] = 8'hFF;
        vld[0] = 1'b1;
        @(posedge clk);
        #1 dat[0] = 8'h00;
        for (int i = 0; i < 2 * FL; i++) begin
            @(negedge clk);
            check("b2b_x_valid", 32'(xv[0]), 1);
            check("b2b_x", 32'(xs[0]), 32'(i < 8));
            if (i == FL - 1) begin
                check("b2b_ready_final", 32'(rdy[0]), 1);
                @(posedge clk);
                #1 vld[0] = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_idle", 32'(xv[0]), 0);
        exp_wc[0] = exp_wc[0] + 16'd2;
        check("b2b_word_count", 32'(wc[0]), 32'(exp_wc[0]));
        // GAP=2: second word queued, accepted only once back in IDLE.
        wait_ready(2);
        dat[2] = 8'hB4;
        vld[2] = 1'b1;
        @(posedge clk);
        #1 dat[2] = 8'h07;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            check("gap_f1_x_valid", 32'(xv[2]), 1);
        end
        z = 0;
        nr = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (xv[2]) break;
            z++;
            if (!rdy[2]) nr++;
            else begin
                check("gap_idle_busy", 32'(bsy[2]), 0);
                @(posedge clk);
                #1 vld[2] = 1'b0;
            end
        end
        check("gap_idle_cycles", 32'(z), 3);
        check("gap_not_ready_cycles", 32'(nr), 2);
        check("gap_f2_first_x", 32'(xs[2]), 0);
        check("gap_f2_first_valid", 32'(xv[2]), 1);
        for (int i = 1; i < FL; i++) @(negedge clk);
        check("gap_f2_last", 32'(ls[2]), 1);
        check("gap_f2_final_x", 32'(xs[2]), P ? 1 : 1);
        @(negedge clk);
        exp_wc[2] = exp_wc[2] + 16'd2;
        check("gap_word_count", 32'(wc[2]), 32'(exp_wc[2]));
        // Asynchronous reset after the third bit of B4.
        wait_ready(0);
        dat[0] = 8'hB4;
        vld[0] = 1'b1;
        @(posedge clk);
        #1 vld[0] = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("pre_rst_x", 32'(xs[0]), 1);
        #1 reset = 1'b1;
        #1;
        check("async_rst_x", 32'(xs[0]), 0);
        check("async_rst_x_valid", 32'(xv[0]), 0);
        check("async_rst_busy", 32'(bsy[0]), 0);
        check("async_rst_ready", 32'(rdy[0]), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(rdy[0]), 1);
        check("post_rst_word_count", 32'(wc[0]), 0);
        check("post_rst_x_valid", 32'(xv[0]), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
